// File: rtl/t04_mem_arbiter_pkg.sv
// Shared types and limits for the shared-memory-port arbiter.
// Latency: none (types only). Backpressure: n/a.
package t04_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // req sampled in cycle 0 gives ack in cycle 2 against a zero-wait memory
    localparam int ARB_MIN_LATENCY = 2;
    localparam int ARB_MIN_CLIENTS = 2;
    localparam int ARB_MAX_CLIENTS = 8;

endpackage

// File: rtl/t04_mem_arbiter_if.sv
// Client request/ack bundle plus the single memory port, as seen by the arbiter (slave) and its environment (master).
// Latency: none (wiring only). Backpressure: req held until ack; mem_busy stalls completion.
interface t04_mem_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = DATA_W / 8
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);

    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS-1:0]        we;
    logic [NUM_CLIENTS*ADDR_W-1:0] adr;
    logic [NUM_CLIENTS*DATA_W-1:0] wdata;
    logic [NUM_CLIENTS*SEL_W-1:0]  sel;
    logic [NUM_CLIENTS-1:0]        ack;
    logic [DATA_W-1:0]             rdata;
    logic [IDX_W-1:0]              grant_idx;
    logic                          grant_vld;
    logic                          mem_write;
    logic                          mem_read;
    logic [ADDR_W-1:0]             mem_adr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [SEL_W-1:0]              mem_sel;
    logic [DATA_W-1:0]             mem_rdata;
    logic                          mem_busy;

    modport slave (
        input  req, we, adr, wdata, sel, mem_rdata, mem_busy,
        output ack, rdata, grant_idx, grant_vld,
               mem_write, mem_read, mem_adr, mem_wdata, mem_sel
    );

    modport master (
        output req, we, adr, wdata, sel, mem_rdata, mem_busy,
        input  ack, rdata, grant_idx, grant_vld,
               mem_write, mem_read, mem_adr, mem_wdata, mem_sel
    );

endinterface

// File: rtl/t04_mem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first requester after ptr (mod N), skipping masked indices.
// Latency: 0 cycles. Backpressure: none.
module t04_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     excl_mask,
    output logic [IDX_W-1:0] win_idx,
    output logic             found
);

    logic [N-1:0] cand;

    assign cand = req & ~excl_mask;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            automatic int pos = (int'(ptr) + k) % N;
            if (!found && cand[pos]) begin
                found   = 1'b1;
                win_idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/t04_mem_arbiter.sv
// N-client arbiter for one shared memory port: strict-priority RT client, round-robin for the rest.
// Latency: req in cycle 0 -> mem strobe cycle 1 -> ack cycle 2 (+1 per mem_busy cycle); one idle cycle between grants.
// Backpressure: one transaction in flight; req held until ack; mem_busy stretches ARB_WAIT. Option: T04_ARB_STARVE_LIMIT_EN.
module t04_mem_arbiter
    import t04_arb_pkg::*;
#(
    parameter int NUM_CLIENTS  = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int SEL_W        = DATA_W / 8,
    parameter int RT_CLIENT    = 1,
    parameter int MAX_RT_BURST = 8
) (
    input  logic clk,
    input  logic nRst,
    t04_mem_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam logic [NUM_CLIENTS-1:0] RT_MASK = NUM_CLIENTS'(1) << RT_CLIENT;

    generate
        if (NUM_CLIENTS < ARB_MIN_CLIENTS || NUM_CLIENTS > ARB_MAX_CLIENTS ||
            RT_CLIENT < 0 || RT_CLIENT >= NUM_CLIENTS || MAX_RT_BURST < 1) begin : g_bad_param
            $error("t04_mem_arbiter: parameter out of range");
        end
    endgenerate

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               grant_vld_q, grant_vld_d;
    logic               we_q, we_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]  mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               rr_found;
    logic               rt_req;
    logic               others_pend;
    logic               rt_block;
    logic               pick_rt;
    logic               grant_now;
    logic               done;

    t04_rr_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req       (bus.req),
        .ptr       (ptr_q),
        .excl_mask (RT_MASK),
        .win_idx   (rr_idx),
        .found     (rr_found)
    );

    assign rt_req      = bus.req[RT_CLIENT];
    assign others_pend = |(bus.req & ~RT_MASK);
    assign pick_rt     = rt_req && !rt_block;
    assign win_idx     = pick_rt ? IDX_W'(RT_CLIENT) : rr_idx;
    assign grant_now   = (state_q == ARB_IDLE) && (pick_rt || rr_found);
    assign done        = (state_q == ARB_WAIT) && !bus.mem_busy;

`ifdef T04_ARB_STARVE_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_RT_BURST + 1);

    logic [CNT_W-1:0] burst_q, burst_d;

    // Once the RT client has won MAX_RT_BURST times in a row over waiting peers, yield one grant.
    assign rt_block = others_pend && (burst_q >= CNT_W'(MAX_RT_BURST));

    always_comb begin
        burst_d = burst_q;
        if (grant_now) begin
            if (pick_rt && others_pend) begin
                burst_d = burst_q + 1'b1;
            end else begin
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign rt_block = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        grant_vld_d = grant_vld_q;
        we_d        = we_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        rdata_d     = rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant_now) begin
                    state_d     = ARB_ISSUE;
                    grant_idx_d = win_idx;
                    grant_vld_d = 1'b1;
                    we_d        = bus.we[win_idx];
                    mem_write_d = bus.we[win_idx];
                    mem_read_d  = ~bus.we[win_idx];
                    mem_adr_d   = bus.adr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = bus.wdata[win_idx*DATA_W +: DATA_W];
                    mem_sel_d   = bus.sel[win_idx*SEL_W +: SEL_W];
                    // RT wins do not disturb the rotation among the other clients
                    if (!pick_rt) begin
                        ptr_d = rr_idx;
                    end
                end
            end
            ARB_ISSUE: begin
                mem_write_d = 1'b0;
                mem_read_d  = 1'b0;
                state_d     = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (done) begin
                    grant_vld_d = 1'b0;
                    state_d     = ARB_IDLE;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= IDX_W'(NUM_CLIENTS - 1);
            grant_vld_q <= 1'b0;
            we_q        <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            grant_vld_q <= grant_vld_d;
            we_q        <= we_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            rdata_q     <= rdata_d;
        end
    end

    // Read data is forwarded in the ack cycle itself, then held in rdata_q.
    assign bus.ack       = done ? (NUM_CLIENTS'(1) << grant_idx_q) : '0;
    assign bus.rdata     = (done && !we_q) ? bus.mem_rdata : rdata_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_sel   = mem_sel_q;

endmodule

// File: tb/tb_t04_mem_arbiter.sv
// Randomized bench for t04_mem_arbiter against a transaction-timeline reference model.
module tb_t04_mem_arbiter;
    import t04_arb_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int RT  = 1;
    localparam int MRB = 2;

    localparam int MODE_QUIET = 0;
    localparam int MODE_HOLD  = 1;
    localparam int MODE_RAND  = 2;

    logic clk = 1'b0;
    logic nRst;

    always #5 clk = ~clk;

    t04_mem_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

    t04_mem_arbiter #(
        .NUM_CLIENTS  (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .SEL_W        (SW),
        .RT_CLIENT    (RT),
        .MAX_RT_BURST (MRB)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode     = MODE_QUIET;
    logic [N-1:0] hold_mask;

    // Reference model: one transaction on a timeline (grant cycle -> issue -> ack)
    bit            m_active;
    int            m_owner, m_issue_cyc, m_ack_cyc, m_ptr, m_streak;
    int            last_ack_client, last_ack_cyc;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_sel;
    int            grant_log[$];
    int            exp_seq[6];
    bit            rst_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active        = 1'b0;
        m_ptr           = N - 1;
        m_streak        = 0;
        m_rdata         = '0;
        last_ack_client = -1;
        last_ack_cyc    = -10;
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        bit others = |(r & ~(N'(1) << RT));
        bit rt_ok  = r[RT];
`ifdef T04_ARB_STARVE_LIMIT_EN
        if (m_streak >= MRB && others) rt_ok = 1'b0;
`endif
        if (rt_ok) begin
            m_streak = others ? m_streak + 1 : 0;
            return RT;
        end
        for (int k = 1; k <= N; k++) begin
            automatic int c = (m_ptr + k) % N;
            if (c != RT && r[c]) begin
                m_ptr    = c;
                m_streak = 0;
                return c;
            end
        end
        return -1;
    endfunction

    function automatic bit wants(input int i);
        case (mode)
            MODE_HOLD: return hold_mask[i];
            MODE_RAND: return (i == RT) ? ($urandom_range(7) == 0) : ($urandom_range(3) == 0);
            default:   return 1'b0;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ack"},   bus.ack, 0);
        chk({tag, "_vld"},   bus.grant_vld, 0);
        chk({tag, "_idx"},   bus.grant_idx, 0);
        chk({tag, "_strb"},  {bus.mem_write, bus.mem_read}, 0);
        chk({tag, "_adr"},   bus.mem_adr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_sel"},   bus.mem_sel, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
    endtask

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            bit renew;
            renew = 1'b0;
            if (last_ack_client == i && cyc == last_ack_cyc + 1) begin
                bus.req[i] = 1'b0;
                renew = wants(i);
            end else if (!bus.req[i] && !(m_active && m_owner == i)) begin
                renew = wants(i);
            end else if (mode == MODE_RAND && m_active && m_owner == i && bus.req[i] &&
                         cyc >= m_issue_cyc && $urandom_range(7) == 0) begin
                bus.req[i] = 1'b0;
            end
            if (renew) begin
                bus.req[i]              = 1'b1;
                bus.we[i]               = 1'($urandom_range(1));
                bus.adr[i*AW +: AW]     = $urandom;
                bus.wdata[i*DW +: DW]   = $urandom;
                bus.sel[i*SW +: SW]     = SW'($urandom);
            end
        end
    endtask

    task automatic model_check();
        if (!m_active) begin
            chk("idle_vld",   bus.grant_vld, 0);
            chk("idle_ack",   bus.ack, 0);
            chk("idle_strb",  {bus.mem_write, bus.mem_read}, 0);
            chk("idle_rdata", bus.rdata, m_rdata);
            if (|bus.req) begin
                automatic int w    = model_pick(bus.req);
                automatic int busy = (mode == MODE_RAND) ? $urandom_range(3) : 0;
                m_active    = 1'b1;
                m_owner     = w;
                m_issue_cyc = cyc + 1;
                m_ack_cyc   = cyc + ARB_MIN_LATENCY + busy;
                m_we        = bus.we[w];
                m_adr       = bus.adr[w*AW +: AW];
                m_wdata     = bus.wdata[w*DW +: DW];
                m_sel       = bus.sel[w*SW +: SW];
                grant_log.push_back(w);
            end
        end else if (cyc == m_issue_cyc) begin
            chk("issue_vld",   bus.grant_vld, 1);
            chk("issue_idx",   bus.grant_idx, m_owner);
            chk("issue_write", bus.mem_write, m_we);
            chk("issue_read",  bus.mem_read, !m_we);
            chk("issue_adr",   bus.mem_adr, m_adr);
            chk("issue_wdata", bus.mem_wdata, m_wdata);
            chk("issue_sel",   bus.mem_sel, m_sel);
            chk("issue_ack",   bus.ack, 0);
        end else begin
            chk("wait_strb", {bus.mem_write, bus.mem_read}, 0);
            chk("wait_vld",  bus.grant_vld, 1);
            chk("wait_adr",  bus.mem_adr, m_adr);
            chk("wait_sel",  bus.mem_sel, m_sel);
            if (cyc == m_ack_cyc) begin
                chk("ack_vec", bus.ack, N'(1) << m_owner);
                if (!m_we) m_rdata = bus.mem_rdata;
                chk("ack_rdata", bus.rdata, m_rdata);
                m_active        = 1'b0;
                last_ack_client = m_owner;
                last_ack_cyc    = cyc;
            end else begin
                chk("wait_ack", bus.ack, 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.mem_busy  = m_active && (cyc > m_issue_cyc) && (cyc < m_ack_cyc);
        bus.mem_rdata = $urandom;
        drive_clients();
        @(negedge clk);
        model_check();
    endtask

    task automatic quiesce(input string tag);
        mode = MODE_QUIET;
        for (int n = 0; n < 200 && (m_active || |bus.req); n++) step();
        chk(tag, {m_active, |bus.req}, 0);
    endtask

    task automatic run_sequence(input string tag, input logic [N-1:0] mask);
        grant_log.delete();
        mode      = MODE_HOLD;
        hold_mask = mask;
        for (int n = 0; n < 200 && grant_log.size() < 6; n++) step();
        chk({tag, "_count"}, grant_log.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk({tag, "_order"}, grant_log[i], exp_seq[i]);
        end
    endtask

    task automatic mid_reset();
        #2 nRst = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_hold");
        bus.req      = '0;
        bus.mem_busy = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        model_reset();
    endtask

    initial begin
        nRst          = 1'b0;
        bus.req       = '0;
        bus.we        = '0;
        bus.adr       = '0;
        bus.wdata     = '0;
        bus.sel       = '0;
        bus.mem_rdata = '0;
        bus.mem_busy  = 1'b0;
        hold_mask     = '0;
        rst_done      = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        nRst = 1'b1;

        exp_seq = '{0, 2, 3, 0, 2, 3};
        run_sequence("rr", 4'b1101);
        quiesce("quiesce_rr");

`ifdef T04_ARB_STARVE_LIMIT_EN
        exp_seq = '{1, 1, 0, 1, 1, 0};
`else
        exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
        run_sequence("rt_prio", 4'b0011);
        quiesce("quiesce_rt");

        mode = MODE_RAND;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst_done && n > 1500 && m_active && cyc == m_issue_cyc + 1 && m_ack_cyc > cyc) begin
                mid_reset();
                rst_done = 1'b1;
            end
        end
        chk("mid_reset_reached", rst_done, 1);
        quiesce("quiesce_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
